// File: rtl/vmac_array.sv
// Multi-lane multiply-accumulate with a two-register valid/ready pipeline.
// S1 registers the products and sideband; S2 adds, saturates and holds the per-lane accumulators.
module vmac_array #(
    parameter int LANES = 4,
    parameter int EW    = 16,
    parameter int AW    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*EW-1:0]   a,
    input  logic [LANES*EW-1:0]   b,
    input  logic [LANES*AW-1:0]   c,
    input  logic [LANES-1:0]      lane_mask,
    input  logic                  op_signed,
    input  logic                  acc_mode,
    input  logic                  acc_clr,
    input  logic                  sat_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*AW-1:0]   y,
    output logic [LANES-1:0]      sat_flag
);

    generate
        if (2 * EW > AW) begin : g_bad_width
            $error("vmac_array: 2*EW must not exceed AW");
        end
    endgenerate

    localparam logic [AW-1:0] S_MAX    = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] S_MIN    = {1'b1, {(AW-1){1'b0}}};
    localparam logic [AW-1:0] U_MAX    = {AW{1'b1}};
    localparam logic [AW-1:0] EXT_MASK = {AW{1'b1}} << (2 * EW);

    logic                 w_s1_adv;
    logic                 w_s2_adv;
    logic                 r_s1_valid;
    logic [AW-1:0]        r_s1_prod [LANES];
    logic [AW-1:0]        r_s1_c    [LANES];
    logic [LANES-1:0]     r_s1_mask;
    logic                 r_s1_signed;
    logic                 r_s1_acc_mode;
    logic                 r_s1_acc_clr;
    logic                 r_s1_sat_en;
    logic                 r_s2_valid;
    logic [LANES*AW-1:0]  r_y;
    logic [LANES-1:0]     r_sat;
    logic [AW-1:0]        r_acc     [LANES];
    logic [AW-1:0]        w_prod    [LANES];
    logic [AW-1:0]        w_add     [LANES];
    logic [AW:0]          w_sum     [LANES];
    logic                 w_ovf     [LANES];
    logic [AW-1:0]        w_y       [LANES];

    // Low 2*EW bits of the product are identical for signed and unsigned once the
    // operands are extended accordingly; only the widening to AW differs.
    function automatic logic [AW-1:0] mul_ext(input logic [EW-1:0] x, input logic [EW-1:0] z,
                                              input logic sgn);
        logic [2*EW-1:0] xe;
        logic [2*EW-1:0] ze;
        logic [2*EW-1:0] p;
        xe = sgn ? {{EW{x[EW-1]}}, x} : {{EW{1'b0}}, x};
        ze = sgn ? {{EW{z[EW-1]}}, z} : {{EW{1'b0}}, z};
        p  = xe * ze;
        mul_ext = AW'(p);
        if (sgn && p[2*EW-1]) begin
            mul_ext = mul_ext | EXT_MASK;
        end
    endfunction

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign out_valid = r_s2_valid;
    assign y         = r_y;
    assign sat_flag  = r_sat;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_prod[i] = mul_ext(a[i*EW +: EW], b[i*EW +: EW], op_signed);
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_add[i] = r_s1_acc_clr ? '0 : (r_s1_acc_mode ? r_acc[i] : r_s1_c[i]);
            if (r_s1_signed) begin
                w_sum[i] = {w_add[i][AW-1], w_add[i]} + {r_s1_prod[i][AW-1], r_s1_prod[i]};
                w_ovf[i] = !r_s1_mask[i] && (w_sum[i][AW] ^ w_sum[i][AW-1]);
            end else begin
                w_sum[i] = {1'b0, w_add[i]} + {1'b0, r_s1_prod[i]};
                w_ovf[i] = !r_s1_mask[i] && w_sum[i][AW];
            end
            if (r_s1_mask[i]) begin
                w_y[i] = w_add[i];
            end else if (w_ovf[i] && r_s1_sat_en) begin
                // Signed overflow direction is given by the true sign bit of the AW+1 sum.
                w_y[i] = !r_s1_signed ? U_MAX : (w_sum[i][AW] ? S_MIN : S_MAX);
            end else begin
                w_y[i] = w_sum[i][AW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_mask     <= '0;
            r_s1_signed   <= 1'b0;
            r_s1_acc_mode <= 1'b0;
            r_s1_acc_clr  <= 1'b0;
            r_s1_sat_en   <= 1'b0;
            r_s2_valid    <= 1'b0;
            r_y           <= '0;
            r_sat         <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_s1_prod[i] <= '0;
                r_s1_c[i]    <= '0;
                r_acc[i]     <= '0;
            end
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_mask     <= lane_mask;
                    r_s1_signed   <= op_signed;
                    r_s1_acc_mode <= acc_mode;
                    r_s1_acc_clr  <= acc_clr;
                    r_s1_sat_en   <= sat_en;
                    for (int i = 0; i < LANES; i++) begin
                        r_s1_prod[i] <= w_prod[i];
                        r_s1_c[i]    <= c[i*AW +: AW];
                    end
                end
            end
            // Accumulators update on the S2 capture edge so the next beat sees them at once.
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    for (int i = 0; i < LANES; i++) begin
                        r_y[i*AW +: AW] <= w_y[i];
                        r_sat[i]        <= w_ovf[i];
                        if ((r_s1_acc_mode || r_s1_acc_clr) && !r_s1_mask[i]) begin
                            r_acc[i] <= w_y[i];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/vmac_array.md
VMAC_ARRAY -- requirements
Module: vmac_array

Interface
- REQ-001: Parameter LANES, default 4, number of independent MAC lanes.
- REQ-002: Parameter EW, default 16, operand element width in bits.
- REQ-003: Parameter AW, default 32, addend/accumulator/result width in bits; 2*EW > AW SHALL raise an elaboration error.
- REQ-004: clk  input  1  single clock; all state updates on the rising edge.
- REQ-005: rst_n  input  1  asynchronous, active-low reset.
- REQ-006: in_valid  input  1  input beat offered.
- REQ-007: in_ready  output  1  input beat accepted when in_valid and in_ready are both high.
- REQ-008: a, b  input  LANES*EW each  packed operands; lane i occupies bits [i*EW +: EW].
- REQ-009: c  input  LANES*AW  packed external addends; lane i occupies bits [i*AW +: AW].
- REQ-010: lane_mask  input  LANES  per-lane mask; 1 = lane passes its addend through.
- REQ-011: op_signed  input  1  1 = two's-complement arithmetic; 0 = unsigned; applies to all lanes of the beat.
- REQ-012: acc_mode  input  1  1 = addend is the lane's internal accumulator instead of c.
- REQ-013: acc_clr  input  1  1 = addend forced to 0 for this beat (overrides acc_mode and c).
- REQ-014: sat_en  input  1  1 = saturate on overflow; 0 = wrap modulo 2^AW.
- REQ-015: out_valid  output  1  result beat available.
- REQ-016: out_ready  input  1  result beat consumed when out_valid and out_ready are both high.
- REQ-017: y  output  LANES*AW  packed results, same lane packing as c.
- REQ-018: sat_flag  output  LANES  per-lane overflow flag, qualified by out_valid.

Function
- REQ-019: Two-register pipeline: S1 captures the product and sideband signals; S2 captures the sum; latency from acceptance to out_valid is exactly 2 cycles when out_ready is held high.
- REQ-020: Full throughput of 1 beat per cycle when out_ready is held high.
- REQ-021: Stall rules: S2 advances when !s2_valid || out_ready; S1 advances when !s1_valid || S2 advances; in_ready = !s1_valid || S1 advances (combinational, no dependency on in_valid).
- REQ-022: A stalled stage holds all of its data; y and sat_flag SHALL stay stable while out_valid && !out_ready; no beat is lost, duplicated or reordered.
- REQ-023: Product: EW x EW giving 2*EW bits; sign-extended to AW when op_signed=1, zero-extended otherwise.
- REQ-024: Addend selection occurs in S2: 0 if acc_clr; else acc[i] if acc_mode; else c lane (registered in S1).
- REQ-025: The sum is computed at AW+1 bits; overflow is detected per op_signed.
- REQ-026: Saturation limits: signed clamps to 0x7FFF_FFFF or 0x8000_0000 (for AW=32); unsigned clamps to 2^AW-1.
- REQ-027: sat_flag[i] = 1 on overflow regardless of sat_en.
- REQ-028: Masked lane: y = selected addend, sat_flag = 0, acc[i] unchanged.
- REQ-029: acc[i] is loaded with the lane's final y when a beat enters S2 with (acc_mode || acc_clr) && !lane_mask[i].
- REQ-030: acc is not updated for any other beat.
- REQ-031: Back-to-back accumulate beats SHALL see the previous beat's result with no bubble, because acc is updated on the same edge S2 captures.

Reset
- REQ-032: While rst_n is low, asynchronously: s1_valid = s2_valid = 0, out_valid = 0, y = 0, sat_flag = 0, every acc[i] = 0.
- REQ-033: in_ready = 1 from the first edge after reset release.
- REQ-034: Reset asserted mid-stall discards all in-flight beats; no partial beat appears after release.

Verification (LANES=4, EW=16, AW=32)
- REQ-035: Unsigned beat a={3,10,255,0}, b={4,10,2,7}, c={5,0,1,9}, out_ready=1 -> 2 cycles later y={17,100,511,9}, sat_flag=0.
- REQ-036: Signed beats a=-3, b=4, c=10, then a=-5, b=-5, c=0 on consecutive cycles -> y=0xFFFF_FFFE then 25 on consecutive cycles.
- REQ-037: Mask lane_mask=4'b0010 with lane1 a=12, b=3, c=50 -> lane1 y=50 and other lanes computed normally; with acc_mode=1, lane1 acc is unchanged.
- REQ-038: Accumulate: acc_clr beat with a=2, b=3, then 4 acc_mode beats with a=2, b=3 -> y sequence 6, 12, 18, 24, 30 with no idle cycles.
- REQ-039: Signed c=0x7FFF_FFF0, a=16, b=1 -> sat_en=1 gives y=0x7FFF_FFFF and sat_flag=1; sat_en=0 gives y=0x8000_0000 and sat_flag=1; unsigned c=0xFFFF_FFFF, a=1, b=1, sat_en=1 gives y=0xFFFF_FFFF.
- REQ-040: Backpressure: out_ready=0 for 5 cycles while beats are offered continuously -> exactly 2 beats accepted, then in_ready=0; the 3rd beat is accepted on the cycle out_ready rises; order is preserved; rst_n pulsed low during the stall -> out_valid=0 and acc=0 immediately.
